otp_stream_xor: RTL and testbench
=================================

Name: otp_stream_xor

Overview:
- Byte-stream one-time-pad encryptor. Sits directly downstream of the team's D flip-flop register cells, which hold key material, and directly upstream of the ciphertext output register.
- Buffers key bytes in a small FIFO. XORs each accepted plaintext byte with exactly one key byte and presents the ciphertext with valid/ready handshaking.
- Enforces single use of key material: every key byte is consumed once, then zeroized.

Parameters:
- DATA_W, 8, width of key, plaintext and ciphertext words.
- KEY_DEPTH, 4, key FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- clear  in  1  synchronous key flush and zeroize.
- key_valid  in  1  key byte offered.
- key_ready  out  1  key byte can be accepted.
- key_data  in  DATA_W  key byte.
- pt_valid  in  1  plaintext byte offered.
- pt_ready  out  1  plaintext byte can be accepted.
- pt_data  in  DATA_W  plaintext byte.
- ct_valid  out  1  ciphertext byte present.
- ct_ready  in  1  downstream accepts ciphertext.
- ct_data  out  DATA_W  ciphertext byte.
- key_count  out  $clog2(KEY_DEPTH+1)  number of unused key bytes held.
- key_underrun  out  1  sticky: plaintext was offered while no key was available.

Behaviour:
- Reset:
  - While reset=0 (asynchronous): ct_valid=0, ct_data=0, key_count=0, key_underrun=0, key_ready=0, pt_ready=0.
  - All FIFO entries are zeroed and the pointers cleared.
- Transfers: a transfer occurs on a rising clk edge when valid&&ready on that channel.
- key_ready = reset && !clear && (key_count != KEY_DEPTH).
  - When the FIFO is full, key_ready=0, even if a pop occurs in the same cycle. There is no full-bypass.
- pt_ready = reset && !clear && (key_count != 0) && (!ct_valid || ct_ready).
  - When the FIFO is empty, pt_ready=0, even if a key is pushed in the same cycle. There is no empty-bypass.
- Plaintext transfer:
  - ct_data <= pt_data ^ fifo_head; ct_valid <= 1.
  - The head entry is popped and overwritten with 0.
- Latency and throughput: latency is 1 cycle from plaintext accept to ct_valid. Throughput is 1 byte/cycle with ct_ready=1.
- Output hold: while ct_valid=1 and ct_ready=0, ct_data and ct_valid hold stable and no key is consumed.
- Output drop: a ciphertext transfer with no new plaintext transfer in the same cycle sets ct_valid <= 0. ct_data keeps its value.
- key_count:
  - +1 on a key transfer, -1 on a plaintext transfer, unchanged when both occur together.
  - Range is 0..KEY_DEPTH. Pointers wrap modulo KEY_DEPTH.
- key_underrun:
  - Set at a clock edge where pt_valid=1 && key_count==0 && reset && !clear.
  - Stays set until clear or reset.
- clear (clock edge with clear=1):
  - FIFO emptied, all entries zeroed, key_count=0, key_underrun=0, ct_valid=0, ct_data=0.
  - No transfers occur in that cycle.
- Reset mid-operation: buffered keys and any pending ciphertext are discarded immediately, without waiting for a clock edge.
- Arithmetic: XOR is bitwise over DATA_W. There are no carries and no width growth.

Decomposition:
- Shared package otp_pkg:
  - default DATA_W constant;
  - typedef for the data word;
  - zeroize constant (all-zeros word).
- One sub-module, otp_key_fifo: the KEY_DEPTH x DATA_W register-based FIFO with push/pop, count, synchronous flush-with-zeroize, and asynchronous active-low reset.
- Handshake logic, XOR and the output register stay in otp_stream_xor.

Test Plan:
- Basic stream:
  - Stimulus: after reset, push keys 0xA5 then 0x3C; send pt 0xFF then 0x00 back-to-back with ct_ready=1.
  - Response: ct_data 0x5A then 0x3C, each 1 cycle after its accept; key_count 2 -> 1 -> 0; pt_ready=0 afterwards.
- Full FIFO:
  - Stimulus: push 4 keys; offer a 5th (0x77) held valid; then send one pt.
  - Response: key_count=4 and key_ready=0 until the pt is accepted; 0x77 is accepted the cycle after, and key_count returns to 4.
- Underrun:
  - Stimulus: pt_valid=1 with pt 0x22 on an empty FIFO; then push key 0x11.
  - Response: pt_ready=0 and key_underrun=1 while empty; pt accepted after the key lands; ct_data=0x33; key_underrun stays 1 until clear.
- Backpressure:
  - Stimulus: keys 0x0F, 0xF0; pts 0x01, 0x02; ct_ready=0 for 3 cycles, then 1.
  - Response: ct_data=0x0E held stable, pt_ready=0, key_count=1 throughout the stall; then 0xF2 follows.
- Async reset mid-operation:
  - Stimulus: 2 keys buffered and ct_valid=1; drop reset between clock edges.
  - Response: ct_valid=0, ct_data=0, key_count=0, key_ready=0 immediately; after release, key_ready=1 and the old keys are gone.
- Clear:
  - Stimulus: 3 keys buffered and key_underrun=1; pulse clear for one cycle.
  - Response: next edge key_count=0, key_underrun=0, ct_valid=0; a following key 0x5A and pt 0x5A give ct_data=0x00.

Source files
------------

// File: rtl/otp_stream_xor_pkg.sv
// Shared definitions for the one-time-pad stream encryptor: default word width,
// the data word type and the zeroize pattern written over spent key material.
package otp_pkg;

   localparam int DEFAULT_DATA_W = 8;

   typedef logic [DEFAULT_DATA_W-1:0] data_t;

   localparam data_t ZERO_WORD = '0;

endpackage

// File: rtl/otp_stream_xor_if.sv
// Valid/ready channels of the encryptor: key input, plaintext input and
// ciphertext output. The encryptor sits on the slave side.
interface otp_stream_xor_if
   import otp_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);

   logic              key_valid;
   logic              key_ready;
   logic [DATA_W-1:0] key_data;

   logic              pt_valid;
   logic              pt_ready;
   logic [DATA_W-1:0] pt_data;

   logic              ct_valid;
   logic              ct_ready;
   logic [DATA_W-1:0] ct_data;

   modport master (
      output key_valid, key_data, input key_ready,
      output pt_valid,  pt_data,  input pt_ready,
      input  ct_valid,  ct_data,  output ct_ready
   );

   modport slave (
      input  key_valid, key_data, output key_ready,
      input  pt_valid,  pt_data,  output pt_ready,
      output ct_valid,  ct_data,  input ct_ready
   );

endinterface

// File: rtl/otp_stream_xor_key_fifo.sv
// Register-based key FIFO. Popped entries are overwritten with zero so that no
// copy of spent key material survives; flush zeroizes the whole array.
module otp_key_fifo
   import otp_pkg::*;
#(
   parameter  int DATA_W    = DEFAULT_DATA_W,
   parameter  int KEY_DEPTH = 4,
   localparam int PTR_W     = $clog2(KEY_DEPTH),
   localparam int CNT_W     = $clog2(KEY_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] pushData_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] headData_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [KEY_DEPTH];
   logic [DATA_W-1:0] mem_d [KEY_DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pushOk;
   logic              popOk;

   assign full_o     = (count_q == CNT_W'(KEY_DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign headData_o = mem_q[rdPtr_q];

   // Guard locally so the FIFO can never over- or under-flow whatever the caller does.
   assign pushOk = push_i && !full_o;
   assign popOk  = pop_i && !empty_o;

   always_comb begin
      mem_d   = mem_q;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         for (int i = 0; i < KEY_DEPTH; i++) begin
            mem_d[i] = DATA_W'(ZERO_WORD);
         end
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (pushOk) begin
            mem_d[wrPtr_q] = pushData_i;
            wrPtr_d        = wrPtr_q + PTR_W'(1);
         end
         if (popOk) begin
            mem_d[rdPtr_q] = DATA_W'(ZERO_WORD);
            rdPtr_d        = rdPtr_q + PTR_W'(1);
         end
         if (pushOk && !popOk) begin
            count_d = count_q + CNT_W'(1);
         end else if (popOk && !pushOk) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q   <= '{default: '0};
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/otp_stream_xor.sv
// One-time-pad byte stream encryptor: each accepted plaintext word is XORed with
// exactly one buffered key word, which is then zeroized.
module otp_stream_xor
   import otp_pkg::*;
#(
   parameter  int DATA_W    = DEFAULT_DATA_W,
   parameter  int KEY_DEPTH = 4,
   localparam int CNT_W     = $clog2(KEY_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   otp_stream_xor_if.slave   bus,
   output logic [CNT_W-1:0]  key_count,
   output logic              key_underrun
);

   logic [DATA_W-1:0] keyHead;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              keyFire;
   logic              ptFire;
   logic              ctFire;

   logic              ctValid_q,  ctValid_d;
   logic [DATA_W-1:0] ctData_q,   ctData_d;
   logic              underrun_q, underrun_d;

   // No bypass paths: readiness depends only on the stored count, never on a
   // same-cycle push or pop, and both are forced low while reset is asserted.
   assign bus.key_ready = reset && !clear && !fifoFull;
   assign bus.pt_ready  = reset && !clear && !fifoEmpty && (!ctValid_q || bus.ct_ready);

   assign keyFire = bus.key_valid && bus.key_ready;
   assign ptFire  = bus.pt_valid && bus.pt_ready;
   assign ctFire  = ctValid_q && bus.ct_ready;

   otp_key_fifo #(
      .DATA_W    (DATA_W),
      .KEY_DEPTH (KEY_DEPTH)
   ) u_keyFifo (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (clear),
      .push_i     (keyFire),
      .pushData_i (bus.key_data),
      .pop_i      (ptFire),
      .headData_o (keyHead),
      .count_o    (key_count),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   // Output register: load on plaintext accept, drop valid once consumed, and
   // keep the last ciphertext word visible after the drop.
   always_comb begin
      ctValid_d  = ctValid_q;
      ctData_d   = ctData_q;
      underrun_d = underrun_q;
      if (clear) begin
         ctValid_d  = 1'b0;
         ctData_d   = DATA_W'(ZERO_WORD);
         underrun_d = 1'b0;
      end else begin
         if (ptFire) begin
            ctValid_d = 1'b1;
            ctData_d  = bus.pt_data ^ keyHead;
         end else if (ctFire) begin
            ctValid_d = 1'b0;
         end
         if (bus.pt_valid && fifoEmpty) begin
            underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctValid_q  <= 1'b0;
         ctData_q   <= '0;
         underrun_q <= 1'b0;
      end else begin
         ctValid_q  <= ctValid_d;
         ctData_q   <= ctData_d;
         underrun_q <= underrun_d;
      end
   end

   assign bus.ct_valid = ctValid_q;
   assign bus.ct_data  = ctData_q;
   assign key_underrun = underrun_q;

endmodule

// File: tb/tb_otp_stream_xor.sv
// Directed bench for the one-time-pad encryptor: each scenario drives the
// handshakes cycle by cycle and compares outputs against hand-computed values.
module tb_otp_stream_xor;

   logic       clk;
   logic       reset;
   logic       clear;
   logic [2:0] keyCount;
   logic       keyUnderrun;
   int         nChecks;
   int         nFails;

   otp_stream_xor_if #(.DATA_W(8)) bus ();

   otp_stream_xor #(
      .DATA_W    (8),
      .KEY_DEPTH (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .bus          (bus),
      .key_count    (keyCount),
      .key_underrun (keyUnderrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge, where registered outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_data  = 8'h00;
      bus.pt_valid  = 1'b0;
      bus.pt_data   = 8'h00;
      bus.ct_ready  = 1'b1;
      #2;
      nChecks++; if (bus.ct_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ct_valid: got %b expected 0", bus.ct_valid); end
      nChecks++; if (bus.ct_data !== 8'h00) begin nFails++; $display("[TB] FAIL reset_ct_data: got %h expected 00", bus.ct_data); end
      nChecks++; if (keyCount !== 3'd0) begin nFails++; $display("[TB] FAIL reset_key_count: got %0d expected 0", keyCount); end
      nChecks++; if (keyUnderrun !== 1'b0) begin nFails++; $display("[TB] FAIL reset_underrun: got %b expected 0", keyUnderrun); end
      nChecks++; if (bus.key_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_key_ready: got %b expected 0", bus.key_ready); end
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pt_ready: got %b expected 0", bus.pt_ready); end
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      nChecks++; if (bus.key_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_release_key_ready: got %b expected 1", bus.key_ready); end
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_release_pt_ready: got %b expected 0", bus.pt_ready); end
   endtask

   task automatic test_basic_stream();
      tick();
      bus.key_valid = 1'b1;
      bus.key_data  = 8'hA5;
      tick();
      bus.key_data  = 8'h3C;
      tick();
      bus.key_valid = 1'b0;
      #1;
      nChecks++; if (keyCount !== 3'd2) begin nFails++; $display("[TB] FAIL basic_count2: got %0d expected 2", keyCount); end
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'hFF;
      bus.ct_ready = 1'b1;
      #1;
      nChecks++; if (bus.pt_ready !== 1'b1) begin nFails++; $display("[TB] FAIL basic_pt_ready: got %b expected 1", bus.pt_ready); end
      tick();
      bus.pt_data = 8'h00;
      #1;
      nChecks++; if (bus.ct_valid !== 1'b1) begin nFails++; $display("[TB] FAIL basic_ct0_valid: got %b expected 1", bus.ct_valid); end
      nChecks++; if (bus.ct_data !== 8'h5A) begin nFails++; $display("[TB] FAIL basic_ct0_data: got %h expected 5a", bus.ct_data); end
      nChecks++; if (keyCount !== 3'd1) begin nFails++; $display("[TB] FAIL basic_count1: got %0d expected 1", keyCount); end
      nChecks++; if (bus.pt_ready !== 1'b1) begin nFails++; $display("[TB] FAIL basic_b2b_ready: got %b expected 1", bus.pt_ready); end
      tick();
      bus.pt_valid = 1'b0;
      #1;
      nChecks++; if (bus.ct_data !== 8'h3C) begin nFails++; $display("[TB] FAIL basic_ct1_data: got %h expected 3c", bus.ct_data); end
      nChecks++; if (bus.ct_valid !== 1'b1) begin nFails++; $display("[TB] FAIL basic_ct1_valid: got %b expected 1", bus.ct_valid); end
      nChecks++; if (keyCount !== 3'd0) begin nFails++; $display("[TB] FAIL basic_count0: got %0d expected 0", keyCount); end
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL basic_pt_ready_empty: got %b expected 0", bus.pt_ready); end
      tick();
      nChecks++; if (bus.ct_valid !== 1'b0) begin nFails++; $display("[TB] FAIL basic_drop: got %b expected 0", bus.ct_valid); end
      nChecks++; if (bus.ct_data !== 8'h3C) begin nFails++; $display("[TB] FAIL basic_drop_data: got %h expected 3c", bus.ct_data); end
   endtask

   task automatic test_full_fifo();
      logic [7:0] expKeys [4];
      expKeys = '{8'h02, 8'h03, 8'h04, 8'h77};
      bus.key_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.key_data = 8'(i + 1);
         tick();
      end
      bus.key_data = 8'h77;
      #1;
      nChecks++; if (keyCount !== 3'd4) begin nFails++; $display("[TB] FAIL full_count4: got %0d expected 4", keyCount); end
      nChecks++; if (bus.key_ready !== 1'b0) begin nFails++; $display("[TB] FAIL full_key_ready: got %b expected 0", bus.key_ready); end
      tick();
      nChecks++; if (keyCount !== 3'd4) begin nFails++; $display("[TB] FAIL full_hold_count: got %0d expected 4", keyCount); end
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'h10;
      bus.ct_ready = 1'b1;
      #1;
      nChecks++; if (bus.key_ready !== 1'b0) begin nFails++; $display("[TB] FAIL full_no_bypass: got %b expected 0", bus.key_ready); end
      nChecks++; if (bus.pt_ready !== 1'b1) begin nFails++; $display("[TB] FAIL full_pt_ready: got %b expected 1", bus.pt_ready); end
      tick();
      bus.pt_valid = 1'b0;
      #1;
      nChecks++; if (bus.ct_data !== 8'h11) begin nFails++; $display("[TB] FAIL full_ct_data: got %h expected 11", bus.ct_data); end
      nChecks++; if (keyCount !== 3'd3) begin nFails++; $display("[TB] FAIL full_count3: got %0d expected 3", keyCount); end
      nChecks++; if (bus.key_ready !== 1'b1) begin nFails++; $display("[TB] FAIL full_key_ready_again: got %b expected 1", bus.key_ready); end
      tick();
      bus.key_valid = 1'b0;
      #1;
      nChecks++; if (keyCount !== 3'd4) begin nFails++; $display("[TB] FAIL full_refill: got %0d expected 4", keyCount); end
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         nChecks++; if (bus.ct_data !== expKeys[i]) begin nFails++; $display("[TB] FAIL full_drain%0d: got %h expected %h", i, bus.ct_data, expKeys[i]); end
      end
      bus.pt_valid = 1'b0;
      tick();
      nChecks++; if (keyCount !== 3'd0) begin nFails++; $display("[TB] FAIL full_drained: got %0d expected 0", keyCount); end
   endtask

   task automatic test_underrun();
      nChecks++; if (keyUnderrun !== 1'b0) begin nFails++; $display("[TB] FAIL underrun_pre: got %b expected 0", keyUnderrun); end
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'h22;
      #1;
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL underrun_pt_ready: got %b expected 0", bus.pt_ready); end
      tick();
      nChecks++; if (keyUnderrun !== 1'b1) begin nFails++; $display("[TB] FAIL underrun_set: got %b expected 1", keyUnderrun); end
      bus.key_valid = 1'b1;
      bus.key_data  = 8'h11;
      #1;
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL underrun_no_bypass: got %b expected 0", bus.pt_ready); end
      tick();
      bus.key_valid = 1'b0;
      #1;
      nChecks++; if (bus.pt_ready !== 1'b1) begin nFails++; $display("[TB] FAIL underrun_pt_ready_after_key: got %b expected 1", bus.pt_ready); end
      tick();
      bus.pt_valid = 1'b0;
      #1;
      nChecks++; if (bus.ct_data !== 8'h33) begin nFails++; $display("[TB] FAIL underrun_ct_data: got %h expected 33", bus.ct_data); end
      nChecks++; if (bus.ct_valid !== 1'b1) begin nFails++; $display("[TB] FAIL underrun_ct_valid: got %b expected 1", bus.ct_valid); end
      tick();
      nChecks++; if (keyUnderrun !== 1'b1) begin nFails++; $display("[TB] FAIL underrun_sticky: got %b expected 1", keyUnderrun); end
   endtask

   task automatic test_clear();
      bus.key_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.key_data = 8'hAA + 8'(i * 17);
         tick();
      end
      bus.key_valid = 1'b0;
      bus.ct_ready  = 1'b0;
      bus.pt_valid  = 1'b1;
      bus.pt_data   = 8'h00;
      tick();
      bus.pt_valid = 1'b0;
      #1;
      nChecks++; if (keyCount !== 3'd3) begin nFails++; $display("[TB] FAIL clear_pre_count: got %0d expected 3", keyCount); end
      nChecks++; if (bus.ct_data !== 8'hAA) begin nFails++; $display("[TB] FAIL clear_pre_ct: got %h expected aa", bus.ct_data); end
      nChecks++; if (keyUnderrun !== 1'b1) begin nFails++; $display("[TB] FAIL clear_pre_underrun: got %b expected 1", keyUnderrun); end
      clear = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_data  = 8'hEE;
      #1;
      nChecks++; if (bus.key_ready !== 1'b0) begin nFails++; $display("[TB] FAIL clear_key_ready: got %b expected 0", bus.key_ready); end
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL clear_pt_ready: got %b expected 0", bus.pt_ready); end
      tick();
      clear = 1'b0;
      bus.key_valid = 1'b0;
      bus.ct_ready  = 1'b1;
      #1;
      nChecks++; if (keyCount !== 3'd0) begin nFails++; $display("[TB] FAIL clear_count: got %0d expected 0", keyCount); end
      nChecks++; if (keyUnderrun !== 1'b0) begin nFails++; $display("[TB] FAIL clear_underrun: got %b expected 0", keyUnderrun); end
      nChecks++; if (bus.ct_valid !== 1'b0) begin nFails++; $display("[TB] FAIL clear_ct_valid: got %b expected 0", bus.ct_valid); end
      nChecks++; if (bus.ct_data !== 8'h00) begin nFails++; $display("[TB] FAIL clear_ct_data: got %h expected 00", bus.ct_data); end
      bus.key_valid = 1'b1;
      bus.key_data  = 8'h5A;
      tick();
      bus.key_valid = 1'b0;
      bus.pt_valid  = 1'b1;
      bus.pt_data   = 8'h5A;
      tick();
      bus.pt_valid = 1'b0;
      nChecks++; if (bus.ct_valid !== 1'b1) begin nFails++; $display("[TB] FAIL clear_after_valid: got %b expected 1", bus.ct_valid); end
      nChecks++; if (bus.ct_data !== 8'h00) begin nFails++; $display("[TB] FAIL clear_after_data: got %h expected 00", bus.ct_data); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.key_valid = 1'b1;
      bus.key_data  = 8'h0F;
      tick();
      bus.key_data  = 8'hF0;
      tick();
      bus.key_valid = 1'b0;
      bus.ct_ready  = 1'b0;
      bus.pt_valid  = 1'b1;
      bus.pt_data   = 8'h01;
      tick();
      bus.pt_data = 8'h02;
      for (int i = 0; i < 3; i++) begin
         #1;
         nChecks++; if (bus.ct_data !== 8'h0E) begin nFails++; $display("[TB] FAIL bp_hold_data%0d: got %h expected 0e", i, bus.ct_data); end
         nChecks++; if (bus.ct_valid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_hold_valid%0d: got %b expected 1", i, bus.ct_valid); end
         nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL bp_pt_ready%0d: got %b expected 0", i, bus.pt_ready); end
         nChecks++; if (keyCount !== 3'd1) begin nFails++; $display("[TB] FAIL bp_count%0d: got %0d expected 1", i, keyCount); end
         tick();
      end
      bus.ct_ready = 1'b1;
      #1;
      nChecks++; if (bus.pt_ready !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release_ready: got %b expected 1", bus.pt_ready); end
      tick();
      bus.pt_valid = 1'b0;
      nChecks++; if (bus.ct_data !== 8'hF2) begin nFails++; $display("[TB] FAIL bp_ct2_data: got %h expected f2", bus.ct_data); end
      nChecks++; if (bus.ct_valid !== 1'b1) begin nFails++; $display("[TB] FAIL bp_ct2_valid: got %b expected 1", bus.ct_valid); end
      tick();
      nChecks++; if (bus.ct_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bp_drop: got %b expected 0", bus.ct_valid); end
   endtask

   task automatic test_async_reset();
      bus.key_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.key_data = 8'h12 + 8'(i * 8'h22);
         tick();
      end
      bus.key_valid = 1'b0;
      bus.ct_ready  = 1'b0;
      bus.pt_valid  = 1'b1;
      bus.pt_data   = 8'h00;
      tick();
      bus.pt_valid = 1'b0;
      #1;
      nChecks++; if (bus.ct_data !== 8'h12) begin nFails++; $display("[TB] FAIL arst_pre_ct: got %h expected 12", bus.ct_data); end
      nChecks++; if (keyCount !== 3'd2) begin nFails++; $display("[TB] FAIL arst_pre_count: got %0d expected 2", keyCount); end
      #1;
      reset = 1'b0;
      #1;
      nChecks++; if (bus.ct_valid !== 1'b0) begin nFails++; $display("[TB] FAIL arst_ct_valid: got %b expected 0", bus.ct_valid); end
      nChecks++; if (bus.ct_data !== 8'h00) begin nFails++; $display("[TB] FAIL arst_ct_data: got %h expected 00", bus.ct_data); end
      nChecks++; if (keyCount !== 3'd0) begin nFails++; $display("[TB] FAIL arst_count: got %0d expected 0", keyCount); end
      nChecks++; if (bus.key_ready !== 1'b0) begin nFails++; $display("[TB] FAIL arst_key_ready: got %b expected 0", bus.key_ready); end
      tick();
      tick();
      reset = 1'b1;
      bus.ct_ready = 1'b1;
      #1;
      nChecks++; if (bus.key_ready !== 1'b1) begin nFails++; $display("[TB] FAIL arst_release_key_ready: got %b expected 1", bus.key_ready); end
      nChecks++; if (bus.pt_ready !== 1'b0) begin nFails++; $display("[TB] FAIL arst_release_pt_ready: got %b expected 0", bus.pt_ready); end
      bus.key_valid = 1'b1;
      bus.key_data  = 8'h00;
      tick();
      bus.key_valid = 1'b0;
      bus.pt_valid  = 1'b1;
      bus.pt_data   = 8'h9C;
      tick();
      bus.pt_valid = 1'b0;
      nChecks++; if (bus.ct_data !== 8'h9C) begin nFails++; $display("[TB] FAIL arst_old_keys_gone: got %h expected 9c", bus.ct_data); end
      nChecks++; if (keyCount !== 3'd0) begin nFails++; $display("[TB] FAIL arst_final_count: got %0d expected 0", keyCount); end
      tick();
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      $display("[TB] starting otp_stream_xor directed tests");
      test_reset();
      test_basic_stream();
      test_full_fifo();
      test_underrun();
      test_clear();
      test_backpressure();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
